// File: rtl/memoria_mp_pkg.sv
// memoria_pkg: shared state encoding, default sizes and flattened-slice helper for memoria_mp
package memoria_pkg;
  typedef enum logic {IDLE, ATTESA} stato_t;
  localparam int N_DEF = 1024;
  localparam int M_DEF = 32;
  localparam int RITARDO_DEF = 8;
  function automatic int idx(input int p, input int w);
    return p * w;
  endfunction
endpackage

// File: rtl/memoria_mp_porta_ctrl.sv
// porta_ctrl: per-port req/ack handshake FSM counting the access latency and latching the address
module porta_ctrl
  import memoria_pkg::*;
#(
  parameter int IND_SIZE = 10,
  parameter int RITARDO = RITARDO_DEF
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req,
  input  logic [IND_SIZE-1:0] ind,
  output logic [IND_SIZE-1:0] ind_q,
  output logic                done,
  output logic                ack,
  output logic                busy
);
  localparam int CW = $clog2(RITARDO + 1);
  stato_t stato;
  logic [CW-1:0] cnt;
  assign done = stato == ATTESA && cnt == '0;
  // accept in IDLE, count down in ATTESA, complete when the counter reaches zero
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      stato <= IDLE;
      cnt <= '0;
      ind_q <= '0;
      ack <= 1'b0;
      busy <= 1'b0;
    end else begin
      ack <= done;
      if (stato == IDLE) begin
        if (req) begin
          stato <= ATTESA;
          cnt <= CW'(RITARDO - 1);
          ind_q <= ind;
          busy <= 1'b1;
        end
      end else if (done) begin
        stato <= IDLE;
        busy <= 1'b0;
      end else cnt <= cnt - 1'b1;
    end
endmodule

// File: rtl/memoria_mp.sv
// memoria_mp: multi-port memory, port 0 R/W, others read-only, fixed-latency req/ack per port
// Optional MEMORIA_MP_FORWARD_EN: a read completing with a same-address port-0 write returns the new data
module memoria_mp
  import memoria_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter int NR = 2,
  parameter int RITARDO = RITARDO_DEF,
  parameter int IND_SIZE = $clog2(N)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NR-1:0]          req,
  input  logic [NR*IND_SIZE-1:0] ind,
  input  logic                   beta,
  input  logic [M-1:0]           in,
  output logic [NR*M-1:0]        out,
  output logic [NR-1:0]          ack,
  output logic [NR-1:0]          busy
);
  localparam logic [IND_SIZE:0] NL = (IND_SIZE + 1)'(N);
  logic [M-1:0] mem [N] = '{default: '0};
  logic [IND_SIZE-1:0] ind_q [NR];
  logic [NR-1:0] done, ok;
  logic [M-1:0] rd [NR];
  logic beta_q, wr;
  logic [M-1:0] dato_q;
  for (genvar p = 0; p < NR; p++) begin : g_porta
    porta_ctrl #(.IND_SIZE(IND_SIZE), .RITARDO(RITARDO)) u_porta (
      .clock(clock), .reset_n(reset_n), .req(req[p]),
      .ind(ind[idx(p, IND_SIZE) +: IND_SIZE]), .ind_q(ind_q[p]),
      .done(done[p]), .ack(ack[p]), .busy(busy[p])
    );
  end
  assign wr = done[0] && beta_q && ok[0];
  // port 0 write command is captured when its controller accepts (idle means not busy)
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      beta_q <= 1'b0;
      dato_q <= '0;
    end else if (req[0] && !busy[0]) begin
      beta_q <= beta;
      dato_q <= in;
    end
  // storage array survives reset; out-of-range writes are dropped
  always_ff @(posedge clock)
    if (wr) mem[ind_q[0]] <= dato_q;
  // read data per port: zero out of range, optional same-edge forwarding from the port-0 write
  always_comb
    for (int p = 0; p < NR; p++) begin
      ok[p] = {1'b0, ind_q[p]} < NL;
      rd[p] = ok[p] ? mem[ind_q[p]] : '0;
`ifdef MEMORIA_MP_FORWARD_EN
      if (wr && p != 0 && ind_q[p] == ind_q[0]) rd[p] = dato_q;
`else
`endif
    end
  // read results are registered at completion and held until the next read on that port
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) out <= '0;
    else
      for (int p = 0; p < NR; p++)
        if (done[p] && !(p == 0 && beta_q)) out[idx(p, M) +: M] <= rd[p];
endmodule

// File: tb/tb_memoria_mp.sv
// tb_memoria_mp: randomized + directed scoreboard bench for memoria_mp against a write-log reference model
module tb_memoria_mp;
  localparam int N = 1000, M = 32, NR = 4, R = 8, IS = 10;
  typedef struct {int e; bit wr; logic [M-1:0] d;} exp_t;
  typedef struct {int a; logic [M-1:0] d; int c;} wlog_t;
  logic clock = 0, reset_n = 1, beta = 0;
  logic [NR-1:0] req = '0;
  logic [NR*IS-1:0] ind = '0;
  logic [M-1:0] din = '0;
  logic [NR*M-1:0] dout;
  logic [NR-1:0] ack, busy;
  exp_t q [NR][$];
  wlog_t wl [$];
  logic [M-1:0] last_out [NR];
  int acc [NR], free_at [NR];
  int ecnt = 0, total = 0, bad = 0;

  memoria_mp #(.N(N), .M(M), .NR(NR), .RITARDO(R)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .ind(ind), .beta(beta),
    .in(din), .out(dout), .ack(ack), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h expected %h", nm, ecnt, act, exp);
    end
  endtask

  // value seen by a read completing at edge c: the last logged write that lands before it
  function automatic logic [M-1:0] lookup(int a, int c);
    logic [M-1:0] v = '0;
    if (a >= N) return '0;
    foreach (wl[i])
`ifdef MEMORIA_MP_FORWARD_EN
      if (wl[i].a == a && wl[i].c <= c) v = wl[i].d;
`else
      if (wl[i].a == a && wl[i].c < c) v = wl[i].d;
`endif
    return v;
  endfunction

  task automatic accept(int p);
    int a = ecnt + 1;
    int ad = int'(ind[p*IS +: IS]);
    exp_t x;
    x.e = a + R;
    x.wr = p == 0 && beta;
    x.d = '0;
    if (x.wr) begin
      if (ad < N) wl.push_back('{ad, din, a + R});
    end else x.d = lookup(ad, a + R);
    q[p].push_back(x);
    acc[p] = a;
    free_at[p] = a + R + 1;
  endtask

  task automatic tick();
    if (reset_n)
      for (int p = 0; p < NR; p++)
        if (req[p] && ecnt + 1 >= free_at[p]) accept(p);
    @(posedge clock);
    ecnt++;
    #1;
  endtask

  task automatic rq(int p, int a, bit w = 0, logic [M-1:0] d = '0);
    req[p] = 1'b1;
    ind[p*IS +: IS] = IS'(a);
    if (p == 0) begin
      beta = w;
      din = d;
    end
  endtask

  task automatic idle(int n);
    req = '0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    req = '0;
    reset_n = 0;
    for (int i = wl.size() - 1; i >= 0; i--)
      if (wl[i].c > ecnt) wl.delete(i);
    for (int p = 0; p < NR; p++) begin
      q[p].delete();
      last_out[p] = '0;
      acc[p] = -100;
      free_at[p] = 0;
    end
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out", dout, 0);
    tick();
    tick();
    reset_n = 1;
  endtask

  // monitor: every cycle compare ack/busy/out against the scoreboard
  always @(negedge clock) begin : mon
    exp_t x;
    logic ea;
    for (int p = 0; p < NR; p++) begin
      ea = q[p].size() > 0 && q[p][0].e == ecnt;
      chk($sformatf("ack%0d", p), ack[p], ea);
      if (ea) begin
        x = q[p].pop_front();
        if (!x.wr) last_out[p] = x.d;
      end
      chk($sformatf("out%0d", p), dout[p*M +: M], last_out[p]);
      chk($sformatf("busy%0d", p), busy[p], ecnt >= acc[p] && ecnt < acc[p] + R);
    end
  end

  initial begin
    #2;
    do_reset();
    rq(1, 5);
    tick();
    idle(R + 2);
    rq(0, 17, 1, 32'hDEADBEEF);
    tick();
    idle(R + 2);
    rq(1, 17);
    tick();
    idle(R + 2);
    rq(1, 40);
    repeat (40) tick();
    idle(R + 2);
    rq(0, 3, 1, 32'hAAAA);
    tick();
    idle(R + 2);
    rq(0, 3, 1, 32'h1234);
    rq(1, 3);
    tick();
    idle(R + 2);
    rq(0, 9, 1, 32'h77);
    tick();
    idle(R + 2);
    rq(0, 9, 1, 32'h55);
    tick();
    idle(4);
    do_reset();
    rq(1, 9);
    tick();
    idle(R + 2);
    for (int p = 0; p < NR; p++) begin
      rq(0, 20 + p, 1, 32'hC0DE0000 + p);
      tick();
      idle(R + 1);
    end
    for (int p = 0; p < NR; p++) rq(p, 20 + p);
    beta = 0;
    tick();
    idle(R + 2);
    rq(0, 1005, 1, 32'hBAD);
    tick();
    idle(R + 1);
    rq(0, 1005);
    rq(2, 999);
    tick();
    idle(R + 2);
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NR; p++) begin
        req[p] = $urandom_range(0, 9) < 3;
        ind[p*IS +: IS] = IS'($urandom_range(0, 9) == 0 ? $urandom_range(995, 1023) : $urandom_range(0, 15));
      end
      beta = $urandom_range(0, 1) == 1;
      din = $urandom;
      if (i == 150) do_reset();
      else tick();
    end
    idle(R + 3);
    for (int p = 0; p < NR; p++) chk($sformatf("drain%0d", p), q[p].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
